// File: rtl/jf_pkg.sv
// jf_pkg: constants and types shared by the slime control path and its renderer.
//   JF_TICK_VAL : ipcnt value that marks one game tick
//   JF_SLIM_W/H : slime sprite box (34x33), shared with the renderer
//   state_e     : slime freeze FSM states (StDead only with SLIM_FREEZE_SHATTER_EN)
package jf_pkg;

   localparam logic [31:0] JF_TICK_VAL = 32'd6000000;
   localparam int unsigned JF_SLIM_W   = 34;
   localparam int unsigned JF_SLIM_H   = 33;

   typedef enum logic [2:0] {
      StActive,
      StFrozen,
      StWarn,
      StImmune
`ifdef SLIM_FREEZE_SHATTER_EN
      , StDead
`endif
   } state_e;

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational, inclusive axis-aligned box overlap test.
//   a_x_i/a_y_i : top-left of box A (A_W x A_H)
//   b_x_i/b_y_i : top-left of box B (B_W x B_H)
//   overlap_o   : 1 when the boxes share at least one pixel
// Sums are widened by one bit so edges past the screen never wrap.
module box_overlap #(
   parameter int unsigned A_W = 34,
   parameter int unsigned A_H = 33,
   parameter int unsigned B_W = 8,
   parameter int unsigned B_H = 8
) (
   input  logic [9:0] a_x_i,
   input  logic [8:0] a_y_i,
   input  logic [9:0] b_x_i,
   input  logic [8:0] b_y_i,
   output logic       overlap_o
);

   logic [10:0] ax, bx;
   logic [9:0]  ay, by;
   logic        x_ok, y_ok;

   assign ax = {1'b0, a_x_i};
   assign bx = {1'b0, b_x_i};
   assign ay = {1'b0, a_y_i};
   assign by = {1'b0, b_y_i};

   assign x_ok = (bx <= ax + 11'(A_W - 1)) && (bx + 11'(B_W - 1) >= ax);
   assign y_ok = (by <= ay + 10'(A_H - 1)) && (by + 10'(B_H - 1) >= ay);

   assign overlap_o = x_ok & y_ok;

endmodule

// File: rtl/slim_freeze_ctrl.sv
// slim_freeze_ctrl: ice-shot hit detection and freeze/thaw/immunity timing for the slime.
//   clk, rst            : clock, synchronous active-high reset
//   ipcnt               : free-running counter; a tick is ipcnt == TICK_VAL
//   x_slim/y_slim       : slime top-left;  x_shot/y_shot/shot_valid : ice shot
//   slim_frozen         : FROZEN/WARN (and DEAD) level to the renderer
//   thaw_warn           : final WARN_TICKS of a freeze
//   shot_hit            : one-cycle pulse retiring the shot
//   freeze_event        : one-cycle pulse on entry to FROZEN
//   hit_cnt             : accumulated hits
//   slim_dead           : shattered; constant 0 unless SLIM_FREEZE_SHATTER_EN is defined
// All outputs are registered.
module slim_freeze_ctrl
   import jf_pkg::*;
#(
   parameter logic [31:0] TICK_VAL        = JF_TICK_VAL,
   parameter int unsigned SLIM_W          = JF_SLIM_W,
   parameter int unsigned SLIM_H          = JF_SLIM_H,
   parameter int unsigned SHOT_W          = 8,
   parameter int unsigned SHOT_H          = 8,
   parameter int unsigned HITS_TO_FREEZE  = 2,
   parameter int unsigned FREEZE_TICKS    = 120,
   parameter int unsigned WARN_TICKS      = 16,
   parameter int unsigned IMMUNE_TICKS    = 32,
   parameter int unsigned HIT_DECAY_TICKS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ipcnt,
   input  logic [9:0]  x_slim,
   input  logic [8:0]  y_slim,
   input  logic        shot_valid,
   input  logic [9:0]  x_shot,
   input  logic [8:0]  y_shot,
   output logic        slim_frozen,
   output logic        thaw_warn,
   output logic        shot_hit,
   output logic        freeze_event,
   output logic [2:0]  hit_cnt,
   output logic        slim_dead
);

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [15:0] decay_q, decay_d;
   logic [2:0]  hit_cnt_q, hit_cnt_d, cnt_inc;
   logic        hit_lock_q, hit_lock_d;
   logic        shot_hit_q, shot_hit_d;
   logic        freeze_event_q, freeze_event_d;
   logic        slim_frozen_q, slim_frozen_d;
   logic        thaw_warn_q, thaw_warn_d;
   logic        overlap, tick, hit;

   box_overlap #(
      .A_W (SLIM_W),
      .A_H (SLIM_H),
      .B_W (SHOT_W),
      .B_H (SHOT_H)
   ) u_box_overlap (
      .a_x_i     (x_slim),
      .a_y_i     (y_slim),
      .b_x_i     (x_shot),
      .b_y_i     (y_shot),
      .overlap_o (overlap)
   );

   assign tick = (ipcnt == TICK_VAL);
   // hit_lock makes a shot that lingers over the slime count only once.
   assign hit  = shot_valid & overlap & ~hit_lock_q;

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      decay_d        = decay_q;
      hit_cnt_d      = hit_cnt_q;
      shot_hit_d     = 1'b0;
      freeze_event_d = 1'b0;
      cnt_inc        = hit_cnt_q + 3'd1;

      unique case (state_q)
         StActive: begin
            if (hit) begin
               shot_hit_d = 1'b1;
               decay_d    = '0;
               if (cnt_inc == 3'(HITS_TO_FREEZE)) begin
                  state_d        = StFrozen;
                  freeze_event_d = 1'b1;
                  hit_cnt_d      = '0;
                  timer_d        = 16'(FREEZE_TICKS);
               end else begin
                  hit_cnt_d = cnt_inc;
               end
            end else if (tick && (hit_cnt_q != 3'd0)) begin
               if (decay_q == 16'(HIT_DECAY_TICKS - 1)) begin
                  hit_cnt_d = hit_cnt_q - 3'd1;
                  decay_d   = '0;
               end else begin
                  decay_d = decay_q + 16'd1;
               end
            end
         end
         StFrozen: begin
            shot_hit_d = hit;
            if (tick) begin
               timer_d = timer_q - 16'd1;
               if (timer_d == 16'(WARN_TICKS)) state_d = StWarn;
            end
`ifdef SLIM_FREEZE_SHATTER_EN
            if (hit) state_d = StDead;
`endif
         end
         StWarn: begin
            shot_hit_d = hit;
            if (tick) begin
               timer_d = timer_q - 16'd1;
               if (timer_d == 16'd0) begin
                  state_d = StImmune;
                  timer_d = 16'(IMMUNE_TICKS);
               end
            end
`ifdef SLIM_FREEZE_SHATTER_EN
            if (hit) state_d = StDead;
`endif
         end
         StImmune: begin
            shot_hit_d = hit;
            if (tick) begin
               timer_d = timer_q - 16'd1;
               if (timer_d == 16'd0) state_d = StActive;
            end
         end
`ifdef SLIM_FREEZE_SHATTER_EN
         StDead: ;  // held until rst
`endif
         default: state_d = StActive;
      endcase

      if (!shot_valid)     hit_lock_d = 1'b0;
      else if (shot_hit_d) hit_lock_d = 1'b1;
      else                 hit_lock_d = hit_lock_q;

      slim_frozen_d = (state_d == StFrozen) || (state_d == StWarn);
`ifdef SLIM_FREEZE_SHATTER_EN
      if (state_d == StDead) slim_frozen_d = 1'b1;
`endif
      thaw_warn_d = (state_d == StWarn);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StActive;
         timer_q        <= '0;
         decay_q        <= '0;
         hit_cnt_q      <= '0;
         hit_lock_q     <= 1'b0;
         shot_hit_q     <= 1'b0;
         freeze_event_q <= 1'b0;
         slim_frozen_q  <= 1'b0;
         thaw_warn_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         decay_q        <= decay_d;
         hit_cnt_q      <= hit_cnt_d;
         hit_lock_q     <= hit_lock_d;
         shot_hit_q     <= shot_hit_d;
         freeze_event_q <= freeze_event_d;
         slim_frozen_q  <= slim_frozen_d;
         thaw_warn_q    <= thaw_warn_d;
      end
   end

`ifdef SLIM_FREEZE_SHATTER_EN
   logic slim_dead_q;
   always_ff @(posedge clk) begin
      if (rst) slim_dead_q <= 1'b0;
      else     slim_dead_q <= (state_d == StDead);
   end
   assign slim_dead = slim_dead_q;
`else
   assign slim_dead = 1'b0;
`endif

   assign slim_frozen  = slim_frozen_q;
   assign thaw_warn    = thaw_warn_q;
   assign shot_hit     = shot_hit_q;
   assign freeze_event = freeze_event_q;
   assign hit_cnt      = hit_cnt_q;

endmodule

// File: tb/tb_slim_freeze_ctrl.sv
// tb_slim_freeze_ctrl: directed scenarios plus randomized play against a tick-counting
// reference model of the slime freeze rules. Honours SLIM_FREEZE_SHATTER_EN.
module tb_slim_freeze_ctrl;

   localparam logic [31:0] TICK   = 32'd6000000;
   localparam int          HITS   = 2;
   localparam int          FREEZE = 120;
   localparam int          WARN   = 16;
   localparam int          IMMUNE = 32;
   localparam int          DECAY  = 64;
`ifdef SLIM_FREEZE_SHATTER_EN
   localparam bit          SHATTER = 1'b1;
`else
   localparam bit          SHATTER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ipcnt;
   logic [9:0]  x_slim, x_shot;
   logic [8:0]  y_slim, y_shot;
   logic        shot_valid;
   logic        slim_frozen, thaw_warn, shot_hit, freeze_event, slim_dead;
   logic [2:0]  hit_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int hit_pulses;

   // Reference model: remaining frozen ticks / immune ticks, hits, idle ticks.
   int m_hits, m_idle, m_frozen_left, m_immune_left;
   bit m_lock, m_dead, e_shot_hit, e_freeze_event;

   always #5 clk = ~clk;

   slim_freeze_ctrl u_dut (
      .clk          (clk),
      .rst          (rst),
      .ipcnt        (ipcnt),
      .x_slim       (x_slim),
      .y_slim       (y_slim),
      .shot_valid   (shot_valid),
      .x_shot       (x_shot),
      .y_shot       (y_shot),
      .slim_frozen  (slim_frozen),
      .thaw_warn    (thaw_warn),
      .shot_hit     (shot_hit),
      .freeze_event (freeze_event),
      .hit_cnt      (hit_cnt),
      .slim_dead    (slim_dead)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input bit tick);
      int xs, ys, xh, yh;
      bit ovl, hit;
      if (rst) begin
         m_hits = 0; m_idle = 0; m_frozen_left = 0; m_immune_left = 0;
         m_lock = 0; m_dead = 0; e_shot_hit = 0; e_freeze_event = 0;
         return;
      end
      xs = int'(x_slim); ys = int'(y_slim); xh = int'(x_shot); yh = int'(y_shot);
      ovl = (xh <= xs + 33) && (xh + 7 >= xs) && (yh <= ys + 32) && (yh + 7 >= ys);
      hit = shot_valid && ovl && !m_lock && !m_dead;
      e_shot_hit     = hit;
      e_freeze_event = 0;
      if (m_dead) begin
      end else if (m_frozen_left > 0) begin
         if (hit && SHATTER) begin
            m_dead = 1; m_frozen_left = 0;
         end else if (tick) begin
            m_frozen_left--;
            if (m_frozen_left == 0) m_immune_left = IMMUNE;
         end
      end else if (m_immune_left > 0) begin
         if (tick) m_immune_left--;
      end else if (hit) begin
         m_hits++;
         m_idle = 0;
         if (m_hits == HITS) begin
            m_hits = 0; m_frozen_left = FREEZE; e_freeze_event = 1;
         end
      end else if (tick && m_hits > 0) begin
         m_idle++;
         if (m_idle == DECAY) begin
            m_hits--; m_idle = 0;
         end
      end
      if (!shot_valid) m_lock = 0;
      else if (hit)    m_lock = 1;
   endtask

   function automatic logic [31:0] non_tick();
      logic [31:0] v;
      v = $urandom;
      if (v == TICK) v = v + 32'd1;
      return v;
   endfunction

   // One clock: drive ipcnt, advance the model, then compare on the falling edge.
   task automatic step(input bit do_tick);
      ipcnt = do_tick ? TICK : non_tick();
      model_step(do_tick);
      @(posedge clk);
      @(negedge clk);
      check("shot_hit", shot_hit, e_shot_hit);
      check("freeze_event", freeze_event, e_freeze_event);
      check("hit_cnt", hit_cnt, m_hits);
      check("slim_frozen", slim_frozen, (m_frozen_left > 0) || m_dead);
      check("thaw_warn", thaw_warn, (m_frozen_left > 0) && (m_frozen_left <= WARN));
      check("slim_dead", slim_dead, m_dead);
      if (shot_hit === 1'b1) hit_pulses++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      shot_valid = 1'b0;
      repeat (n) step(1'b0);
      rst = 1'b0;
   endtask

   initial begin
      int frozen_ticks, warn_ticks, immune_pulses;
      logic [9:0] edge_slim [4];
      logic [9:0] edge_shot [4];
      logic       edge_exp  [4];

      rst = 1'b1; shot_valid = 1'b0; ipcnt = '0;
      x_slim = 10'd300; y_slim = 9'd367; x_shot = '0; y_shot = '0;
      @(negedge clk);

      // Reset state
      do_reset(3);
      check("reset_frozen", slim_frozen, 1'b0);
      check("reset_hit_cnt", hit_cnt, 3'd0);

      // Freeze by two accumulated hits
      x_shot = 10'd310; y_shot = 9'd370; hit_pulses = 0;
      shot_valid = 1'b1; step(1'b0); step(1'b0);
      shot_valid = 1'b0; step(1'b0);
      shot_valid = 1'b1; step(1'b0);
      check("acc_hit_pulses", hit_pulses, 2);
      check("acc_freeze_event", freeze_event, 1'b1);
      check("acc_frozen", slim_frozen, 1'b1);

      // Freeze timeline: tick every 20 cycles, shots only while not frozen
      frozen_ticks = 0; warn_ticks = 0; immune_pulses = 0;
      for (int t = 0; t < FREEZE + IMMUNE; t++) begin
         for (int c = 0; c < 20; c++) begin
            shot_valid = !slim_frozen && c[0];
            if (c == 19) begin
               if (slim_frozen) frozen_ticks++;
               if (thaw_warn)   warn_ticks++;
            end
            hit_pulses = 0;
            step(c == 19);
            if (t >= FREEZE) immune_pulses += hit_pulses;
         end
      end
      check("timeline_frozen_ticks", frozen_ticks, FREEZE);
      check("timeline_warn_ticks", warn_ticks, WARN);
      check("timeline_immune_hits_seen", immune_pulses > 0, 1'b1);
      check("timeline_immune_cnt", hit_cnt, 3'd0);
      check("timeline_thawed", slim_frozen, 1'b0);

      // Reset mid-freeze drops slim_frozen at once
      shot_valid = 1'b0; step(1'b0);
      shot_valid = 1'b1; step(1'b0);
      shot_valid = 1'b0; step(1'b0);
      shot_valid = 1'b1; step(1'b0);
      check("refreeze", slim_frozen, 1'b1);
      do_reset(1);
      check("reset_mid_freeze", slim_frozen, 1'b0);

      // Single-count guard
      hit_pulses = 0; shot_valid = 1'b1;
      repeat (10) step(1'b0);
      check("guard_pulses", hit_pulses, 1);
      check("guard_cnt", hit_cnt, 3'd1);

      // Overlap box edges
      edge_slim = '{10'd300, 10'd300, 10'd300, 10'd1000};
      edge_shot = '{10'd333, 10'd334, 10'd292, 10'd10};
      edge_exp  = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         do_reset(1);
         x_slim = edge_slim[i]; y_slim = 9'd367;
         x_shot = edge_shot[i]; y_shot = 9'd367;
         shot_valid = 1'b1;
         step(1'b0);
         check($sformatf("edge_%0d", edge_shot[i]), shot_hit, edge_exp[i]);
      end

      // Hit decay
      do_reset(1);
      x_slim = 10'd300; x_shot = 10'd310;
      shot_valid = 1'b1; step(1'b0);
      shot_valid = 1'b0;
      repeat (DECAY - 1) step(1'b1);
      check("decay_before", hit_cnt, 3'd1);
      step(1'b1);
      check("decay_after", hit_cnt, 3'd0);
      shot_valid = 1'b1; step(1'b0);
      check("decay_rehit_cnt", hit_cnt, 3'd1);
      check("decay_rehit_frozen", slim_frozen, 1'b0);

`ifdef SLIM_FREEZE_SHATTER_EN
      // Shatter: hit while frozen, held until reset
      shot_valid = 1'b0; step(1'b0);
      shot_valid = 1'b1; step(1'b0);
      shot_valid = 1'b0; step(1'b0);
      shot_valid = 1'b1; step(1'b0);
      check("shatter_dead", slim_dead, 1'b1);
      shot_valid = 1'b0;
      repeat (40) step(1'b1);
      check("shatter_held", slim_dead, 1'b1);
      check("shatter_frozen", slim_frozen, 1'b1);
      do_reset(1);
      check("shatter_reset", slim_dead, 1'b0);
`endif

      // Randomized play
      do_reset(1);
      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            x_slim = 10'($urandom_range(0, 1023));
            y_slim = 9'($urandom_range(0, 511));
         end
         x_shot = 10'(32'(x_slim) + $urandom_range(0, 52) - 12);
         y_shot = 9'(32'(y_slim) + $urandom_range(0, 50) - 12);
         shot_valid = ($urandom_range(0, 1) == 0);
         rst = ($urandom_range(0, 599) == 0);
         step($urandom_range(0, 2) == 0);
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
